apb_master: RTL and testbench
=============================

// Module: apb_master
// PURPOSE
//  Command-driven APB initiator: turns a simple valid/ready request into a compliant
//  APB SETUP/ACCESS transfer, waits on PREADY, and returns read data and error status
//  on a valid/ready response port. Drives apb_if (UART register slave) from on-chip
//  logic: one outstanding transfer, no pipelining.
// PARAMETERS
//  ADDR_WIDTH      4   APB address width (PADDR, cmd_addr)
//  DATA_WIDTH      8   APB data width (PWDATA, PRDATA, cmd_wdata, rsp_rdata)
//  TIMEOUT_CYCLES  16  ACCESS cycles with PREADY low before abort (APB_MASTER_TIMEOUT_EN only), >=1
// PORTS
//  PCLK         in   1           single clock, all logic rising-edge
//  PRESETn      in   1           asynchronous active-low reset
//  cmd_valid    in   1           request present
//  cmd_ready    out  1           request accepted when cmd_valid & cmd_ready at PCLK edge
//  cmd_write    in   1           1 = write, 0 = read
//  cmd_addr     in   ADDR_WIDTH  target register address
//  cmd_wdata    in   DATA_WIDTH  write data (ignored for reads)
//  rsp_valid    out  1           response held until rsp_ready
//  rsp_ready    in   1           response consumed when rsp_valid & rsp_ready at PCLK edge
//  rsp_rdata    out  DATA_WIDTH  PRDATA captured on read completion; 0 for writes
//  rsp_err      out  1           PSLVERR captured at completion, or timeout
//  rsp_timeout  out  1           transfer aborted by timeout (constant 0 without macro)
//  PADDR        out  ADDR_WIDTH  APB address
//  PSELx        out  1           APB select
//  PENABLE      out  1           APB enable
//  PWRITE       out  1           APB direction
//  PWDATA       out  DATA_WIDTH  APB write data
//  PREADY       in   1           slave ready
//  PRDATA       in   DATA_WIDTH  slave read data
//  PSLVERR      in   1           slave error, valid only with PREADY in ACCESS
// BEHAVIOUR
//  - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; all APB outputs registered.
//  - Reset (async, any state): state=IDLE; PSELx, PENABLE, PWRITE, rsp_valid,
//    rsp_err, rsp_timeout = 0; PADDR, PWDATA, rsp_rdata = 0. In-flight transfer dropped.
//  - cmd_ready = (state==IDLE), combinational from state only.
//  - IDLE: on accept, latch PADDR, PWRITE; PWDATA = cmd_wdata (write) or 0 (read);
//    PSELx<=1; -> SETUP.
//  - SETUP: exactly one cycle; PENABLE<=1; -> ACCESS.
//  - ACCESS: PADDR/PWRITE/PWDATA/PSELx stable. Edge with PREADY=1: PSELx<=0,
//    PENABLE<=0, rsp_rdata<=PRDATA (read) or 0 (write), rsp_err<=PSLVERR,
//    rsp_valid<=1 -> RESP. PREADY=0: stay (wait states unbounded without macro).
//  - RESP: rsp_* held stable until rsp_ready; on consume rsp_valid<=0 -> IDLE.
//    rsp_ready while rsp_valid=0 has no effect.
//  - Latency, zero-wait slave: accept edge E0; PSELx=1 from E0; PENABLE=1 from E1;
//    completion at E2; rsp_valid=1 from E2. Each PREADY-low cycle adds one.
//  - Min spacing: consume at RESP edge -> cmd_ready=1 next cycle -> next SETUP;
//    PSELx deasserts for >=1 cycle between transfers (no back-to-back ACCESS).
//  - PADDR/PWRITE/PWDATA retain last value after a transfer completes.
// CONFIGURATION
//  APB_MASTER_TIMEOUT_EN defined: counter cleared on entering ACCESS, increments each
//   ACCESS cycle with PREADY=0; when count reaches TIMEOUT_CYCLES and PREADY still 0,
//   end transfer as on completion but rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//   PREADY=1 on the same edge wins (normal completion).
//  Not defined: no counter; rsp_timeout tied 0; ACCESS waits indefinitely.
// TESTING
//  1 Reset: PRESETn=0 mid-ACCESS -> PSELx/PENABLE/rsp_valid=0 immediately; IDLE, cmd_ready=1.
//  2 Write 0x83 to addr 0x4, zero-wait slave -> PSELx high 2 cycles, PENABLE 1 cycle,
//    PWDATA=0x83, rsp_valid from E2, rsp_err=0, rsp_rdata=0.
//  3 Read addr 0x0, slave 1 wait state returning 0x55 -> ACCESS 2 cycles, rsp_rdata=0x55.
//  4 Read with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0; cmd_ready=0 until consumed.
//  5 rsp_ready low 5 cycles after completion -> rsp_* stable, no new SETUP despite cmd_valid=1.
//  6 (APB_MASTER_TIMEOUT_EN) PREADY held 0 -> abort after 16 ACCESS cycles,
//    rsp_err=1, rsp_timeout=1, PSELx=0; following transfer completes normally.

Source files
------------

// File: rtl/apb_master_if.sv
// APB bus bundle between the command-driven initiator and a register slave.
// The master modport drives the select/enable/address/data; the slave answers with
// PREADY/PRDATA/PSLVERR.
interface apb_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) ();
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PSELx;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic                  PREADY;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PSLVERR;

   modport master (
      output PADDR, PSELx, PENABLE, PWRITE, PWDATA,
      input  PREADY, PRDATA, PSLVERR
   );

   modport slave (
      input  PADDR, PSELx, PENABLE, PWRITE, PWDATA,
      output PREADY, PRDATA, PSLVERR
   );
endinterface

// File: rtl/apb_master.sv
// apb_master: turns a valid/ready command into one APB SETUP/ACCESS transfer and
// returns read data and error status on a valid/ready response port. One transfer
// in flight at a time; all APB outputs are registered.
//
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   defined   -> an ACCESS phase with PREADY low for TIMEOUT_CYCLES cycles is
//                aborted and reported with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//   undefined -> ACCESS waits on PREADY indefinitely, rsp_timeout is constant 0.
//
// state  | meaning
// IDLE   | no transfer, cmd_ready=1
// SETUP  | PSELx=1, PENABLE=0 for exactly one cycle
// ACCESS | PSELx=1, PENABLE=1, waiting for PREADY
// RESP   | response presented, waiting for rsp_ready
module apb_master #(
   parameter int ADDR_WIDTH     = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   apb_if.master                 apb
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   logic [1:0] state;

   // Only an idle master can take a command; decoded from state alone.
   assign cmd_ready = (state == ST_IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_cnt;
   logic          tmo_flag;

   assign rsp_timeout = tmo_flag;
`else
   // No abort path: the flag can never be raised. The parameter still appears so a
   // single parameter set works for both builds.
   assign rsp_timeout = 1'b0 & (TIMEOUT_CYCLES >= 1);
`endif

   // Transfer sequencing, APB output registers and response capture.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state       <= ST_IDLE;
         apb.PADDR   <= '0;
         apb.PSELx   <= 1'b0;
         apb.PENABLE <= 1'b0;
         apb.PWRITE  <= 1'b0;
         apb.PWDATA  <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         tmo_cnt     <= '0;
         tmo_flag    <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  apb.PADDR  <= cmd_addr;
                  apb.PWRITE <= cmd_write;
                  apb.PWDATA <= cmd_write ? cmd_wdata : '0;
                  apb.PSELx  <= 1'b1;
                  state      <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               apb.PENABLE <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
               tmo_cnt     <= '0;
`endif
               state       <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // PREADY wins over a timeout on the same edge.
               if (apb.PREADY) begin
                  apb.PSELx   <= 1'b0;
                  apb.PENABLE <= 1'b0;
                  rsp_rdata   <= apb.PWRITE ? '0 : apb.PRDATA;
                  rsp_err     <= apb.PSLVERR;
                  rsp_valid   <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                  tmo_flag    <= 1'b0;
`endif
                  state       <= ST_RESP;
               end
`ifdef APB_MASTER_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  apb.PSELx   <= 1'b0;
                  apb.PENABLE <= 1'b0;
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  tmo_flag    <= 1'b1;
                  rsp_valid   <= 1'b1;
                  state       <= ST_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a table of directed transfers, a reset-in-flight sequence,
// randomized transfers against a memory-backed reference, and (with
// APB_MASTER_TIMEOUT_EN) the timeout abort.
module tb_apb_master;

   logic       PCLK = 1'b0;
   logic       PRESETn;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_rdata;
   logic       rsp_err, rsp_timeout;

   apb_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) apb ();

   apb_master #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .apb         (apb)
   );

   always #5 PCLK = ~PCLK;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] slave_mem [16];
   logic [7:0] ref_mem   [16];

   typedef struct {
      logic       wr;
      logic [3:0] addr;
      logic [7:0] wd;
      int         waits;
      logic       slverr;
      int         hold;
      logic [7:0] exp_rd;
      logic       exp_err;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One full transfer, checked phase by phase. Inputs are driven and outputs sampled
   // on the falling edge.
   task automatic run_txn(input logic wr, input logic [3:0] addr, input logic [7:0] wd,
                          input int waits, input logic slverr, input int hold,
                          input logic [7:0] exp_rd, input logic exp_err);
      logic [7:0] rd_hold;
      logic       err_hold;
      check("cmd_ready_idle", 32'(cmd_ready), 1);
      cmd_valid   = 1'b1;
      cmd_write   = wr;
      cmd_addr    = addr;
      cmd_wdata   = wd;
      apb.PREADY  = 1'b0;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      cmd_addr  = 4'($urandom);
      cmd_wdata = 8'($urandom);
      check("setup_psel",    32'(apb.PSELx), 1);
      check("setup_penable", 32'(apb.PENABLE), 0);
      check("setup_paddr",   32'(apb.PADDR), 32'(addr));
      check("setup_pwrite",  32'(apb.PWRITE), 32'(wr));
      check("setup_pwdata",  32'(apb.PWDATA), wr ? 32'(wd) : 0);
      check("setup_cmd_ready", 32'(cmd_ready), 0);
      @(negedge PCLK);
      check("access_psel",    32'(apb.PSELx), 1);
      check("access_penable", 32'(apb.PENABLE), 1);
      for (int i = 0; i < waits; i++) begin
         @(negedge PCLK);
         check("wait_penable", 32'(apb.PENABLE & apb.PSELx), 1);
         check("wait_paddr",   32'(apb.PADDR), 32'(addr));
         check("wait_rsp_valid", 32'(rsp_valid), 0);
      end
      apb.PREADY  = 1'b1;
      apb.PSLVERR = slverr;
      apb.PRDATA  = slave_mem[apb.PADDR];
      if (apb.PWRITE) slave_mem[apb.PADDR] = apb.PWDATA;
      @(negedge PCLK);
      apb.PREADY  = 1'b0;
      apb.PSLVERR = 1'b0;
      apb.PRDATA  = 8'($urandom);
      check("done_psel",      32'(apb.PSELx), 0);
      check("done_penable",   32'(apb.PENABLE), 0);
      check("done_rsp_valid", 32'(rsp_valid), 1);
      check("done_rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
      check("done_rsp_err",   32'(rsp_err), 32'(exp_err));
      check("done_rsp_timeout", 32'(rsp_timeout), 0);
      check("done_cmd_ready", 32'(cmd_ready), 0);
      check("retain_paddr",   32'(apb.PADDR), 32'(addr));
      rd_hold  = rsp_rdata;
      err_hold = rsp_err;
      cmd_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge PCLK);
         check("hold_rsp_valid", 32'(rsp_valid), 1);
         check("hold_rsp_rdata", 32'(rsp_rdata), 32'(rd_hold));
         check("hold_rsp_err",   32'(rsp_err), 32'(err_hold));
         check("hold_no_setup",  32'(apb.PSELx), 0);
      end
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      check("consumed_rsp_valid", 32'(rsp_valid), 0);
      check("consumed_cmd_ready", 32'(cmd_ready), 1);
      check("consumed_psel",      32'(apb.PSELx), 0);
   endtask

   initial begin
      logic       wr;
      logic [3:0] addr;
      logic [7:0] wd;
      logic [7:0] exp_rd;
      logic       sl;

      tbl[0] = '{1'b1, 4'h4, 8'h83, 0, 1'b0, 0, 8'h00, 1'b0};
      tbl[1] = '{1'b0, 4'h0, 8'h00, 1, 1'b0, 0, 8'h55, 1'b0};
      tbl[2] = '{1'b0, 4'h4, 8'h00, 0, 1'b1, 0, 8'h83, 1'b1};
      tbl[3] = '{1'b0, 4'h4, 8'h00, 2, 1'b0, 5, 8'h83, 1'b0};
      tbl[4] = '{1'b1, 4'hF, 8'hFF, 3, 1'b1, 1, 8'h00, 1'b1};
      tbl[5] = '{1'b0, 4'hF, 8'h00, 0, 1'b0, 2, 8'hFF, 1'b0};

      for (int i = 0; i < 16; i++) begin
         slave_mem[i] = 8'h00;
         ref_mem[i]   = 8'h00;
      end
      slave_mem[0] = 8'h55;
      ref_mem[0]   = 8'h55;

      PRESETn     = 1'b0;
      cmd_valid   = 1'b0;
      cmd_write   = 1'b0;
      cmd_addr    = 4'h0;
      cmd_wdata   = 8'h00;
      rsp_ready   = 1'b0;
      apb.PREADY  = 1'b0;
      apb.PRDATA  = 8'h00;
      apb.PSLVERR = 1'b0;
      repeat (2) @(negedge PCLK);
      check("rst_psel",      32'(apb.PSELx), 0);
      check("rst_penable",   32'(apb.PENABLE), 0);
      check("rst_pwrite",    32'(apb.PWRITE), 0);
      check("rst_paddr",     32'(apb.PADDR), 0);
      check("rst_pwdata",    32'(apb.PWDATA), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 0);
      check("rst_rsp_err",   32'(rsp_err), 0);
      check("rst_cmd_ready", 32'(cmd_ready), 1);
      PRESETn = 1'b1;
      @(negedge PCLK);

      // Directed table
      for (int i = 0; i < 6; i++) begin
         run_txn(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].waits, tbl[i].slverr,
                 tbl[i].hold, tbl[i].exp_rd, tbl[i].exp_err);
         if (tbl[i].wr) ref_mem[tbl[i].addr] = tbl[i].wd;
      end

      // Reset while a transfer sits in ACCESS
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h9; cmd_wdata = 8'hA5;
      apb.PREADY = 1'b0;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      @(negedge PCLK);
      check("pre_rst_penable", 32'(apb.PENABLE), 1);
      #2 PRESETn = 1'b0;
      #1;
      check("midrst_psel",      32'(apb.PSELx), 0);
      check("midrst_penable",   32'(apb.PENABLE), 0);
      check("midrst_rsp_valid", 32'(rsp_valid), 0);
      check("midrst_cmd_ready", 32'(cmd_ready), 1);
      check("midrst_paddr",     32'(apb.PADDR), 0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);
      check("postrst_psel",      32'(apb.PSELx), 0);
      check("postrst_cmd_ready", 32'(cmd_ready), 1);

      // Randomized transfers against the reference memory
      for (int n = 0; n < 24; n++) begin
         wr     = 1'($urandom);
         addr   = 4'($urandom);
         wd     = 8'($urandom);
         sl     = ($urandom_range(0, 3) == 0);
         exp_rd = wr ? 8'h00 : ref_mem[addr];
         run_txn(wr, addr, wd, $urandom_range(0, 3), sl, $urandom_range(0, 3), exp_rd, sl);
         if (wr) ref_mem[addr] = wd;
      end

`ifdef APB_MASTER_TIMEOUT_EN
      begin
         int access_cycles;
         access_cycles = 0;
         cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h4;
         apb.PREADY = 1'b0;
         apb.PRDATA = 8'h3C;
         @(negedge PCLK);
         cmd_valid = 1'b0;
         for (int i = 0; i < 100 && !rsp_valid; i++) begin
            @(negedge PCLK);
            if (apb.PENABLE) access_cycles++;
         end
         check("tmo_rsp_valid",     32'(rsp_valid), 1);
         check("tmo_access_cycles", 32'(access_cycles), 16);
         check("tmo_rsp_err",       32'(rsp_err), 1);
         check("tmo_rsp_timeout",   32'(rsp_timeout), 1);
         check("tmo_rsp_rdata",     32'(rsp_rdata), 0);
         check("tmo_psel",          32'(apb.PSELx), 0);
         rsp_ready = 1'b1;
         @(negedge PCLK);
         rsp_ready = 1'b0;
         run_txn(1'b0, 4'h4, 8'h00, 1, 1'b0, 0, ref_mem[4], 1'b0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
